// File: rtl/lfo_pkg.sv
// rtl/lfo_pkg.sv - shared types and constants for the LFO phase generator
package lfo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_NORM,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    // 2*pi in unsigned Q3.23
    localparam logic [25:0] TWO_PI_Q3_23 = 26'd52707179;
    localparam logic [31:0] FLOAT_ZERO   = 32'h0000_0000;

endpackage

// File: rtl/lfo_phase_gen_if.sv
// rtl/lfo_phase_gen_if.sv - tick/frequency inputs, sine-stage handshake and LFO outputs
interface lfo_phase_gen_if #(
    parameter int PHASE_W = 24
);
    logic               sample_tick;
    logic [PHASE_W-1:0] freq_word;
    logic               phase_clear;
    logic               sin_start;
    logic [31:0]        sin_data;
    logic               sin_done;
    logic [31:0]        sin_result;
    logic [31:0]        lfo_value;
    logic               lfo_valid;
    logic               overrun;
    logic               timeout;

    modport master (
        output sample_tick, freq_word, phase_clear, sin_done, sin_result,
        input  sin_start, sin_data, lfo_value, lfo_valid, overrun, timeout
    );

    modport slave (
        input  sample_tick, freq_word, phase_clear, sin_done, sin_result,
        output sin_start, sin_data, lfo_value, lfo_valid, overrun, timeout
    );
endinterface

// File: rtl/lfo_phase_gen_fix_to_float.sv
// rtl/lfo_phase_gen_fix_to_float.sv - combinational signed fixed-point to binary32 (truncating)
module fix_to_float
    import lfo_pkg::*;
#(
    parameter int IN_W   = 50,
    parameter int FRAC_W = 47
) (
    input  logic signed [IN_W-1:0] i_fix,
    output logic        [31:0]     o_float
);
    localparam int P_W = $clog2(IN_W);

    logic            w_sign;
    logic [IN_W-1:0] w_mag;
    logic [P_W-1:0]  w_lead;
    logic [22:0]     w_mant;
    logic [7:0]      w_exp;

    // Leading-one detect, then take the 23 bits below it as the truncated mantissa
    always_comb begin
        w_sign = i_fix[IN_W-1];
        w_mag  = w_sign ? -i_fix : i_fix;
        w_lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (w_mag[i]) w_lead = P_W'(i);
        end
        w_mant = '0;
        for (int j = 0; j < 23; j++) begin
            int idx;
            idx = int'(w_lead) - 1 - j;
            w_mant[22-j] = (idx >= 0) ? w_mag[idx] : 1'b0;
        end
        w_exp   = 8'(127 - FRAC_W + int'(w_lead));
        o_float = (w_mag == '0) ? FLOAT_ZERO : {w_sign, w_exp, w_mant};
    end
endmodule

// File: rtl/lfo_phase_gen.sv
// rtl/lfo_phase_gen.sv - LFO phase accumulator driving a float sine stage; watchdog via LFO_PHASE_GEN_TIMEOUT_EN
module lfo_phase_gen
    import lfo_pkg::*;
#(
    parameter int PHASE_W        = 24,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    lfo_phase_gen_if.slave  bus
);
    localparam int PROD_W = PHASE_W + 26;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [PHASE_W-1:0]       r_acc;
    state_t                   r_state;
    logic                     r_pending;
    logic signed [PROD_W-1:0] r_prod;
    logic [31:0]              r_sin_data;
    logic [31:0]              r_lfo_value;
    logic                     r_sin_start;
    logic                     r_lfo_valid;
    logic                     r_overrun;
    logic signed [PROD_W-1:0] w_prod;
    logic [31:0]              w_float;

    // Phase as a signed cycle fraction times 2*pi; result has PHASE_W+23 fraction bits
    assign w_prod = $signed({{26{r_acc[PHASE_W-1]}}, r_acc})
                  * $signed({{PHASE_W{1'b0}}, TWO_PI_Q3_23});

    fix_to_float #(
        .IN_W   (PROD_W),
        .FRAC_W (PHASE_W + 23)
    ) u_fix_to_float (
        .i_fix   (r_prod),
        .o_float (w_float)
    );

`ifdef LFO_PHASE_GEN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout;
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    // Accumulator, one-deep tick pending slot and the compute/issue/wait sequencer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_prod      <= '0;
            r_sin_data  <= FLOAT_ZERO;
            r_lfo_value <= FLOAT_ZERO;
            r_sin_start <= 1'b0;
            r_lfo_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef LFO_PHASE_GEN_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_sin_start <= 1'b0;
            r_lfo_valid <= 1'b0;

            if (bus.phase_clear)      r_acc <= '0;
            else if (bus.sample_tick) r_acc <= r_acc + bus.freq_word;

            // Ticks that land while busy collapse into a single pending slot
            if (bus.sample_tick && (r_state != ST_IDLE)) begin
                if (r_pending) r_overrun <= 1'b1;
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.sample_tick || r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_prod  <= w_prod;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_sin_data  <= w_float;
                    r_sin_start <= 1'b1;
                    r_state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
`ifdef LFO_PHASE_GEN_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.sin_done) begin
                        r_lfo_value <= bus.sin_result;
                        r_lfo_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
`ifdef LFO_PHASE_GEN_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sin_start = r_sin_start;
    assign bus.sin_data  = r_sin_data;
    assign bus.lfo_value = r_lfo_value;
    assign bus.lfo_valid = r_lfo_valid;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_lfo_phase_gen.sv
// tb/tb_lfo_phase_gen.sv - scoreboard bench for lfo_phase_gen with a 37-cycle sine-stage model
module tb_lfo_phase_gen;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lfo_phase_gen_if #(.PHASE_W(24)) ifc();

    lfo_phase_gen #(
        .PHASE_W        (24),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc.slave)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        sq[$];
    exp_t        lq[$];
    logic [23:0] m_acc = '0;
    bit          mode_fixed = 0;
    logic [31:0] fixed_data = '0;
    bit          inflight = 0;
    bit          sine_en = 1;
    bit          drop = 0;
    int          n_start = 0;
    int          n_valid = 0;
    logic [31:0] exp_lfo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        $display("FAIL %s: got unexpected event at cycle %0d, expected none", name, cyc);
    endtask

    // Angle of a phase word: signed cycle fraction * 2*pi, rounded toward zero to binary32
    function automatic logic [31:0] ref_angle(input logic [23:0] acc);
        longint s, prod, mag, mant;
        int     p;
        bit     sgn;
        s    = acc[23] ? (longint'(acc) - 64'sd16777216) : longint'(acc);
        prod = s * 64'sd52707179;
        sgn  = (prod < 0);
        mag  = sgn ? -prod : prod;
        if (mag == 0) return 32'h0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        mant = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
        return {sgn, 8'(127 + p - 47), 23'(mant & 64'h7F_FFFF)};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge; drives a one-cycle tick
    task automatic tick(input logic [23:0] f, input bit clr, input bit push_model, output int tc);
        exp_t e;
        ifc.sample_tick = 1'b1;
        ifc.freq_word   = f;
        ifc.phase_clear = clr;
        tc    = cyc;
        m_acc = clr ? 24'h0 : (m_acc + f);
        if (push_model) begin
            e.data = ref_angle(m_acc);
            e.cyc  = tc + 3;
            sq.push_back(e);
        end
        @(negedge clk);
        ifc.sample_tick = 1'b0;
        ifc.phase_clear = 1'b0;
    endtask

    task automatic push_const(input logic [31:0] d, input int tc);
        exp_t e;
        e.data = d;
        e.cyc  = tc + 3;
        sq.push_back(e);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 300 && (inflight || sq.size() > 0 || lq.size() > 0); i++) @(negedge clk);
        if (inflight || sq.size() > 0 || lq.size() > 0) begin
            n_chk++;
            $display("FAIL %s: got outstanding work after 300 cycles, expected drained", name);
        end
    endtask

    // Sine stage: done 37 cycles after start with a random result
    initial begin
        int cnt;
        exp_t e;
        cnt = 0;
        ifc.sin_done   = 1'b0;
        ifc.sin_result = '0;
        forever begin
            @(negedge clk);
            ifc.sin_done   = 1'b0;
            ifc.sin_result = $urandom;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ifc.sin_done = 1'b1;
                    if (!drop) begin
                        e.data = ifc.sin_result;
                        e.cyc  = cyc + 1;
                        lq.push_back(e);
                    end
                end
            end else if (sine_en && ifc.sin_start && !rst) begin
                cnt = 37;
            end
        end
    end

    // Monitor: compares DUT-presented starts and results against the queues
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.sin_start) begin
                    chk("single_in_flight", 32'(inflight), 32'd0);
                    inflight = 1;
                    n_start++;
                    if (mode_fixed) begin
                        chk("ovr_sin_data", ifc.sin_data, fixed_data);
                    end else if (sq.size() == 0) begin
                        fail_evt("sin_start_unexpected");
                    end else begin
                        e = sq.pop_front();
                        chk("sin_data", ifc.sin_data, e.data);
                        chk("sin_start_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (ifc.lfo_valid) begin
                    inflight = 0;
                    n_valid++;
                    if (lq.size() == 0) begin
                        fail_evt("lfo_valid_unexpected");
                    end else begin
                        e = lq.pop_front();
                        exp_lfo = e.data;
                        chk("lfo_value", ifc.lfo_value, e.data);
                        chk("lfo_valid_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int tc, s, st0, va0;
        ifc.sample_tick = 1'b0;
        ifc.freq_word   = '0;
        ifc.phase_clear = 1'b0;
        idle(3);
        chk("rst_sin_data", ifc.sin_data, 32'h0);
        chk("rst_lfo_value", ifc.lfo_value, 32'h0);
        chk("rst_sin_start", 32'(ifc.sin_start), 32'd0);
        chk("rst_lfo_valid", 32'(ifc.lfo_valid), 32'd0);
        chk("rst_overrun", 32'(ifc.overrun), 32'd0);
        chk("rst_timeout", 32'(ifc.timeout), 32'd0);
        rst = 1'b0;
        idle(2);

        // Quarter-cycle steps: +pi/2, -pi, -pi/2, 0
        tick(24'h400000, 0, 0, tc); push_const(32'h3FC90FDA, tc); idle(99);
        tick(24'h400000, 0, 0, tc); push_const(32'hC0490FDA, tc); idle(99);
        tick(24'h400000, 0, 0, tc); push_const(32'hBFC90FDA, tc); idle(99);
        tick(24'h400000, 0, 0, tc); push_const(32'h00000000, tc); idle(99);
        drain("drain_quarter");

        // Clear beats a simultaneous tick, which still computes at phase 0
        tick(24'h123456, 0, 1, tc); idle(60);
        tick(24'($urandom), 1, 0, tc); push_const(32'h00000000, tc); idle(60);
        drain("drain_clear");

        // Randomized isolated ticks
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                ifc.phase_clear = 1'b1;
                m_acc = '0;
                @(negedge clk);
                ifc.phase_clear = 1'b0;
            end
            tick(24'($urandom), ($urandom_range(0, 5) == 0), 1, tc);
            idle(45 + $urandom_range(0, 12));
        end
        drain("drain_random");
        chk("overrun_idle_spaced", 32'(ifc.overrun), 32'd0);

        // Ticks every 10 cycles with freq 0: every computation sees the same phase
        mode_fixed = 1;
        fixed_data = ref_angle(m_acc);
        st0 = n_start;
        va0 = n_valid;
        for (int k = 0; k < 12; k++) begin
            tick(24'h0, 0, 0, tc);
            if (k == 1) chk("overrun_after_2nd", 32'(ifc.overrun), 32'd0);
            if (k == 2) chk("overrun_after_3rd", 32'(ifc.overrun), 32'd1);
            idle(9);
        end
        drain("drain_overrun");
        mode_fixed = 0;
        chk("ovr_start_eq_valid", 32'(n_start - st0), 32'(n_valid - va0));
        chk("ovr_back_to_back", 32'((n_start - st0) >= 3), 32'd1);
        chk("overrun_sticky", 32'(ifc.overrun), 32'd1);

        // Reset during WAIT aborts; the late done must be ignored
        tick(24'($urandom), 0, 1, tc);
        while (cyc < tc + 13) @(negedge clk);
        drop = 1;
        rst  = 1'b1;
        @(negedge clk);
        chk("abort_sin_data", ifc.sin_data, 32'h0);
        chk("abort_lfo_value", ifc.lfo_value, 32'h0);
        chk("abort_overrun", 32'(ifc.overrun), 32'd0);
        chk("abort_sin_start", 32'(ifc.sin_start), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        inflight = 0;
        m_acc    = '0;
        exp_lfo  = '0;
        idle(45);
        drop = 0;
        chk("abort_no_valid", 32'(lq.size()), 32'd0);
        chk("abort_lfo_value_held", ifc.lfo_value, 32'h0);

        // Accumulator restarts from zero after reset
        tick(24'h200000, 0, 0, tc); push_const(32'h3F490FDA, tc); idle(50);
        drain("drain_after_abort");

`ifdef LFO_PHASE_GEN_TIMEOUT_EN
        sine_en = 0;
        tick(24'($urandom), 0, 1, tc);
        s = tc + 3;
        while (cyc < s + 64) @(negedge clk);
        chk("timeout_before_limit", 32'(ifc.timeout), 32'd0);
        @(negedge clk);
        chk("timeout_at_limit", 32'(ifc.timeout), 32'd1);
        chk("timeout_lfo_unchanged", ifc.lfo_value, exp_lfo);
        inflight = 0;
        sine_en  = 1;
        tick(24'($urandom), 0, 1, tc);
        idle(50);
        drain("drain_after_timeout");
        chk("timeout_sticky", 32'(ifc.timeout), 32'd1);
`else
        s = 0;
        chk("timeout_tied_low", 32'(ifc.timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lfo_phase_gen.md
# lfo_phase_gen

Low-frequency-oscillator phase source for the modulation effects (chorus, flanger, tremolo). On each audio sample tick it advances a fixed-point phase accumulator, converts the wrapped phase to an IEEE-754 single-precision angle in radians, [-π, π), and launches one computation on the downstream fixed-latency floating-point sine stage. It waits for that stage's `done` and republishes the sine result as the LFO output sample. It sits directly upstream of the sine stage and drives its `clk_en`/`data` pair.

## Interface
- PHASE_W, 24: accumulator and frequency-word width (bits).
- TIMEOUT_CYCLES, 64: watchdog limit in cycles; used only with the timeout feature.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle audio sample strobe.
- freq_word  in  PHASE_W  unsigned phase increment per tick; sampled on the tick.
- phase_clear  in  1  zeroes the accumulator at the next edge.
- sin_start  out  1  one-cycle start pulse to the sine stage's `clk_en`.
- sin_data  out  32  float angle to the sine stage; held stable from `sin_start` until `sin_done`.
- sin_done  in  1  completion pulse from the sine stage.
- sin_result  in  32  float sine value; valid while `sin_done` is high.
- lfo_value  out  32  last sine result.
- lfo_valid  out  1  one-cycle pulse when `lfo_value` updates.
- overrun  out  1  sticky; a tick arrived while a tick was already pending.
- timeout  out  1  sticky watchdog flag; tied 0 when the feature is compiled out.

## Operation
- Reset: accumulator=0, state IDLE, pending=0. All outputs are 0: `lfo_value`=0x00000000, `sin_data`=0x00000000, all flags 0.
- Accumulator update at each edge:
  - `phase_clear` → 0. Clear wins over a simultaneous tick, but that tick still schedules a computation, at phase 0.
  - Else on `sample_tick` → acc + freq_word, modulo 2^PHASE_W.
- The accumulator advances on every tick regardless of state.
- Angle conversion:
  - Treat acc as a signed fraction of a cycle in [-0.5, 0.5).
  - Multiply by TWO_PI_Q3_23 = 52707179 (unsigned 26-bit). The product is signed, PHASE_W+26 bits; rad = product / 2^(PHASE_W+23).
  - Float conversion: sign = MSB; magnitude = absolute value; leading-one position p sets exponent = 127 + p − (PHASE_W+23).
  - Mantissa = the 23 bits below the leading one, truncated (no rounding).
  - A magnitude of zero gives 0x00000000.
- FSM:
  - IDLE: on a tick, or on pending=1, go to CONV and clear pending.
  - CONV: register the product; go to NORM.
  - NORM: register the converted float into `sin_data`; go to ISSUE.
  - ISSUE: `sin_start`=1 for this cycle only; go to WAIT.
  - WAIT: on `sin_done`, latch `sin_result` into `lfo_value`, pulse `lfo_valid` in the next cycle, go to IDLE.
- A tick outside IDLE sets pending=1. If pending is already 1, set `overrun`; no queue deeper than one entry.
- A pending computation uses the accumulator value current at its CONV cycle.
- `sin_done` is ignored in every state except WAIT.
- Reset mid-operation aborts: no further `sin_start`, and no `lfo_valid` for the aborted computation.

## Timing
- Tick high in cycle 0 → CONV in cycle 1 → NORM in cycle 2 → `sin_start` high in cycle 3, with `sin_data` valid from cycle 3.
- `sin_done` high in cycle k → `lfo_value` updated and `lfo_valid` high in cycle k+1.
- Total latency = 4 + sine-stage latency.
- Back-to-back: after WAIT exits, a pending tick re-enters CONV on the next cycle.
- Throughput is one computation per (4 + sine latency) cycles. This is far below one per sample period at audio rates.

## Configuration
- LFO_PHASE_GEN_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If `sin_done` has not arrived after TIMEOUT_CYCLES cycles in WAIT: set `timeout`, return to IDLE, leave `lfo_value` unchanged, emit no `lfo_valid`.
- Undefined: no counter; WAIT lasts until `sin_done`; `timeout` is constant 0.

## Structure
- Package `lfo_pkg`: FSM state enum (IDLE, CONV, NORM, ISSUE, WAIT), TWO_PI_Q3_23, FLOAT_ZERO.
- One sub-module, `fix_to_float`:
  - Signed fixed-point to single-precision converter (leading-one detect + shift), purely combinational.
  - Parameterised by input width and fraction bits; instantiated in the NORM path.

## Test plan
- Reset, then freq_word=0x400000 with ticks every 100 cycles. Required `sin_data` sequence: 0x3FC90FDA, 0xC0490FDA, 0xBFC90FDA, 0x00000000.
- Model the sine stage as done 37 cycles after start. Required: tick in cycle 0 → `sin_start` in cycle 3 → `lfo_valid` in cycle 41, with `lfo_value` equal to the model's result.
- phase_clear and tick together with acc=0x123456 → acc=0, and `sin_data`=0x00000000.
- Ticks every 10 cycles with a 37-cycle sine model:
  - `overrun` sets on the third tick of the first window.
  - Exactly one `sin_start` per WAIT exit; never two in flight.
- Assert reset during WAIT, then a late `sin_done` → no `lfo_valid`, all outputs return to 0.
- With LFO_PHASE_GEN_TIMEOUT_EN and `sin_done` held 0 → `timeout`=1 after 64 WAIT cycles, then IDLE. The next tick issues normally.
